// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the BCD calculator controller slice.
//
// Contents:
//   CALC_NDIG         default number of BCD digits per operand
//   CALC_ALU_TIMEOUT  default number of cycles to wait for the arithmetic unit
//   OP_ADD / OP_SUB   operator codes carried on op_val / op_sel
//   state_t           controller state encoding (also exported on state_o)
//   op_is_valid()     true for the two operator codes the controller accepts
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_NDIG        = 4;
    localparam int CALC_ALU_TIMEOUT = 255;

    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    typedef enum logic [1:0] {
        ENT_A    = 2'd0,
        ENT_B    = 2'd1,
        WAIT_ALU = 2'd2,
        SHOW_RES = 2'd3
    } state_t;

    // Codes 0 and 3 are unused by the arithmetic unit, so keys carrying
    // them must not disturb the controller.
    function automatic logic op_is_valid(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/calc_ctrl_key_event.sv
// -----------------------------------------------------------------------------
// key_event
// Turns the level-type key_press from the keypad decoder into a single-cycle
// event, one cycle after the rising edge. The key class flags and the key
// value are captured at that edge, so the controller never sees whatever the
// decoder drives while the key is held or released.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   key_press         high while a decoded key is held
//   is_num/is_op/is_eq key class, valid while key_press is high
//   num_val, op_val   digit / operator code of the key
//   ev_num/ev_op/ev_eq single-cycle event pulses, one per key press
//   ev_num_val        digit captured at the edge
//   ev_op_val         operator code captured at the edge
// -----------------------------------------------------------------------------
module key_event (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_press,
    input  logic       is_num,
    input  logic       is_op,
    input  logic       is_eq,
    input  logic [3:0] num_val,
    input  logic [1:0] op_val,
    output logic       ev_num,
    output logic       ev_op,
    output logic       ev_eq,
    output logic [3:0] ev_num_val,
    output logic [1:0] ev_op_val
);

    logic       prev_q,    prev_d;
    logic       ev_num_q,  ev_num_d;
    logic       ev_op_q,   ev_op_d;
    logic       ev_eq_q,   ev_eq_d;
    logic [3:0] num_val_q, num_val_d;
    logic [1:0] op_val_q,  op_val_d;
    logic       rise;

    // Edge detect against last cycle's key level; the class flags are only
    // turned into events on the edge, and the values are held between edges.
    always_comb begin
        rise      = key_press & ~prev_q;
        prev_d    = key_press;
        ev_num_d  = rise & is_num;
        ev_op_d   = rise & is_op;
        ev_eq_d   = rise & is_eq;
        num_val_d = rise ? num_val : num_val_q;
        op_val_d  = rise ? op_val  : op_val_q;
    end

    // prev_q resets high so a key that is still held when reset is released
    // looks like it was already down and produces no event.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 1'b1;
            ev_num_q  <= 1'b0;
            ev_op_q   <= 1'b0;
            ev_eq_q   <= 1'b0;
            num_val_q <= 4'd0;
            op_val_q  <= 2'd0;
        end else begin
            prev_q    <= prev_d;
            ev_num_q  <= ev_num_d;
            ev_op_q   <= ev_op_d;
            ev_eq_q   <= ev_eq_d;
            num_val_q <= num_val_d;
            op_val_q  <= op_val_d;
        end
    end

    assign ev_num     = ev_num_q;
    assign ev_op      = ev_op_q;
    assign ev_eq      = ev_eq_q;
    assign ev_num_val = num_val_q;
    assign ev_op_val  = op_val_q;

endmodule

// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
// Keypad-driven controller for a BCD calculator. Collects two operands and an
// operator from key events, hands them to an external arithmetic unit, and
// shows the operand being typed or the returned result on disp_val.
//
// Build option:
//   CALC_CHAIN_EN  when defined, an operator key while a result is shown
//                  continues with the result as the first operand. Without
//                  it, operator keys in that state are ignored.
//
// Parameters:
//   NDIG         BCD digits per operand (>= 1)
//   ALU_TIMEOUT  cycles to wait for alu_done before giving up (>= 1)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_press           level, high while a decoded key is held
//   is_num/is_op/is_eq  key class
//   num_val, op_val     digit (0-9) / operator (1 add, 2 sub)
//   alu_start           one-cycle request to the arithmetic unit
//   alu_done            one-cycle completion strobe
//   alu_result          BCD result, valid with alu_done
//   opnd_a, opnd_b      BCD operands, stable while the ALU works
//   op_sel              latched operator
//   disp_val            value to display
//   err                 sticky ALU-timeout flag, cleared by the next digit
//   state_o             current state (debug)
// -----------------------------------------------------------------------------
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG        = CALC_NDIG,
    parameter int ALU_TIMEOUT = CALC_ALU_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_press,
    input  logic              is_num,
    input  logic              is_op,
    input  logic              is_eq,
    input  logic [3:0]        num_val,
    input  logic [1:0]        op_val,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [4*NDIG-1:0] alu_result,
    output logic [4*NDIG-1:0] opnd_a,
    output logic [4*NDIG-1:0] opnd_b,
    output logic [1:0]        op_sel,
    output logic [4*NDIG-1:0] disp_val,
    output logic              err,
    output logic [1:0]        state_o
);

    localparam int DW = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);

    logic       ev_num;
    logic       ev_op;
    logic       ev_eq;
    logic [3:0] ev_num_val;
    logic [1:0] ev_op_val;
    logic       ev_op_ok;

    state_t          state_q,     state_d;
    logic [DW-1:0]   opnd_a_q,    opnd_a_d;
    logic [DW-1:0]   opnd_b_q,    opnd_b_d;
    logic [DW-1:0]   result_q,    result_d;
    logic [DW-1:0]   disp_val_q,  disp_val_d;
    logic [1:0]      op_sel_q,    op_sel_d;
    logic [CW-1:0]   cnt_a_q,     cnt_a_d;
    logic [CW-1:0]   cnt_b_q,     cnt_b_d;
    logic [TW-1:0]   tmo_q,       tmo_d;
    logic            err_q,       err_d;
    logic            alu_start_q, alu_start_d;

    key_event u_key_event (
        .clk        (clk),
        .rst        (rst),
        .key_press  (key_press),
        .is_num     (is_num),
        .is_op      (is_op),
        .is_eq      (is_eq),
        .num_val    (num_val),
        .op_val     (op_val),
        .ev_num     (ev_num),
        .ev_op      (ev_op),
        .ev_eq      (ev_eq),
        .ev_num_val (ev_num_val),
        .ev_op_val  (ev_op_val)
    );

    assign ev_op_ok = ev_op && op_is_valid(ev_op_val);

    // Next-state logic. A key carrying more than one class flag is treated
    // as a digit first, then an operator, then equals. Shifting in a digit
    // uses a size cast to drop the most significant digit's old position.
    always_comb begin
        state_d     = state_q;
        opnd_a_d    = opnd_a_q;
        opnd_b_d    = opnd_b_q;
        result_d    = result_q;
        op_sel_d    = op_sel_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        err_d       = err_q;
        alu_start_d = 1'b0;
        tmo_d       = '0;

        case (state_q)
            ENT_A: begin
                if (ev_num) begin
                    if (cnt_a_q < CNT_FULL) begin
                        opnd_a_d = DW'({opnd_a_q, ev_num_val});
                        cnt_a_d  = cnt_a_q + 1'b1;
                        err_d    = 1'b0;
                    end
                end else if (ev_op_ok) begin
                    op_sel_d = ev_op_val;
                    opnd_b_d = '0;
                    cnt_b_d  = '0;
                    state_d  = ENT_B;
                end
            end

            ENT_B: begin
                if (ev_num) begin
                    if (cnt_b_q < CNT_FULL) begin
                        opnd_b_d = DW'({opnd_b_q, ev_num_val});
                        cnt_b_d  = cnt_b_q + 1'b1;
                        err_d    = 1'b0;
                    end
                end else if (ev_op_ok) begin
                    op_sel_d = ev_op_val;
                end else if (ev_eq) begin
                    alu_start_d = 1'b1;
                    state_d     = WAIT_ALU;
                end
            end

            // Keys are dropped here. A completion on the last allowed cycle
            // still wins over the timeout.
            WAIT_ALU: begin
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = SHOW_RES;
                end else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    opnd_a_d = '0;
                    opnd_b_d = '0;
                    result_d = '0;
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                    state_d  = ENT_A;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            SHOW_RES: begin
                if (ev_num) begin
                    opnd_a_d = DW'(ev_num_val);
                    opnd_b_d = '0;
                    cnt_a_d  = CW'(1);
                    cnt_b_d  = '0;
                    err_d    = 1'b0;
                    state_d  = ENT_A;
                end
`ifdef CALC_CHAIN_EN
                else if (ev_op_ok) begin
                    // The shown result becomes a complete first operand.
                    opnd_a_d = disp_val_q;
                    cnt_a_d  = CNT_FULL;
                    opnd_b_d = '0;
                    cnt_b_d  = '0;
                    op_sel_d = ev_op_val;
                    state_d  = ENT_B;
                end
`endif
            end

            default: begin
                state_d = ENT_A;
            end
        endcase

        // The display follows the state being entered so it lines up with
        // state_o on the same cycle.
        case (state_d)
            ENT_A:   disp_val_d = opnd_a_d;
            ENT_B:   disp_val_d = opnd_b_d;
            default: disp_val_d = result_d;
        endcase
    end

    // All controller state, including every output, lives in this one
    // register block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENT_A;
            opnd_a_q    <= '0;
            opnd_b_q    <= '0;
            result_q    <= '0;
            disp_val_q  <= '0;
            op_sel_q    <= 2'd0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_a_q    <= opnd_a_d;
            opnd_b_q    <= opnd_b_d;
            result_q    <= result_d;
            disp_val_q  <= disp_val_d;
            op_sel_q    <= op_sel_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            alu_start_q <= alu_start_d;
        end
    end

    assign alu_start = alu_start_q;
    assign opnd_a    = opnd_a_q;
    assign opnd_b    = opnd_b_q;
    assign op_sel    = op_sel_q;
    assign disp_val  = disp_val_q;
    assign err       = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
// Self-checking bench for calc_ctrl: a table of key presses with expected
// outputs, hand-written multi-cycle sequences, then random keys and ALU
// responses compared against a behavioural calculator model.
// -----------------------------------------------------------------------------
module tb_calc_ctrl;

    localparam int NDIG = 4;
    localparam int TMO  = 255;
    localparam int DW   = 4 * NDIG;

    // Key kinds used by the stimulus: none, digit, operator, equals.
    localparam int K_NONE = 0;
    localparam int K_NUM  = 1;
    localparam int K_OP   = 2;
    localparam int K_EQ   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_press;
    logic          is_num;
    logic          is_op;
    logic          is_eq;
    logic [3:0]    num_val;
    logic [1:0]    op_val;
    logic          alu_start;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic [1:0]    op_sel;
    logic [DW-1:0] disp_val;
    logic          err;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Reference model: abstract calculator state.
    int m_state;
    int m_a, m_b, m_acnt, m_bcnt;
    int m_op, m_res, m_err, m_starts;

    typedef struct {
        int kind;
        int val;
        int exp_a;
        int exp_b;
        int exp_op;
        int exp_disp;
        int exp_state;
    } vec_t;

    vec_t vecs[17];

    calc_ctrl #(.NDIG(NDIG), .ALU_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_press  (key_press),
        .is_num     (is_num),
        .is_op      (is_op),
        .is_eq      (is_eq),
        .num_val    (num_val),
        .op_val     (op_val),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .op_sel     (op_sel),
        .disp_val   (disp_val),
        .err        (err),
        .state_o    (state_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Every cycle alu_start is high counts once, so a stretched pulse shows
    // up as an extra start.
    always @(posedge clk) begin
        if (alu_start) start_cnt++;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int digitIn(input int cur, input int d);
        return (cur * 16 + d) % (1 << (4 * NDIG));
    endfunction

    function automatic int modelDisp();
        if (m_state == 0) return m_a;
        if (m_state == 1) return m_b;
        return m_res;
    endfunction

    task automatic modelReset();
        m_state = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
        m_op = 0; m_res = 0; m_err = 0;
        m_starts = start_cnt;
    endtask

    task automatic modelKey(input int kind, input int val);
        bit op_ok;
        op_ok = (kind == K_OP) && (val == 1 || val == 2);
        case (m_state)
            0: begin
                if (kind == K_NUM) begin
                    if (m_acnt < NDIG) begin
                        m_a = digitIn(m_a, val); m_acnt++; m_err = 0;
                    end
                end else if (op_ok) begin
                    m_op = val; m_b = 0; m_bcnt = 0; m_state = 1;
                end
            end
            1: begin
                if (kind == K_NUM) begin
                    if (m_bcnt < NDIG) begin
                        m_b = digitIn(m_b, val); m_bcnt++; m_err = 0;
                    end
                end else if (op_ok) begin
                    m_op = val;
                end else if (kind == K_EQ) begin
                    m_starts++; m_state = 2;
                end
            end
            3: begin
                if (kind == K_NUM) begin
                    m_a = val; m_acnt = 1; m_b = 0; m_bcnt = 0;
                    m_err = 0; m_state = 0;
                end
`ifdef CALC_CHAIN_EN
                else if (op_ok) begin
                    m_a = m_res; m_acnt = NDIG; m_b = 0; m_bcnt = 0;
                    m_op = val; m_state = 1;
                end
`endif
            end
            default: ;
        endcase
    endtask

    task automatic modelDone(input int res);
        if (m_state == 2) begin
            m_res = res; m_state = 3;
        end
    endtask

    task automatic modelTimeout();
        if (m_state == 2) begin
            m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
            m_res = 0; m_err = 1; m_state = 0;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " opnd_a"},    opnd_a,    m_a);
        checkOutput({tag, " opnd_b"},    opnd_b,    m_b);
        checkOutput({tag, " op_sel"},    op_sel,    m_op);
        checkOutput({tag, " disp_val"},  disp_val,  modelDisp());
        checkOutput({tag, " err"},       err,       m_err);
        checkOutput({tag, " state"},     state_o,   m_state);
        checkOutput({tag, " alu_start"}, start_cnt, m_starts);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input int kind, input int val, input int hold);
        key_press = 1'b1;
        is_num    = (kind == K_NUM);
        is_op     = (kind == K_OP);
        is_eq     = (kind == K_EQ);
        num_val   = 4'(val);
        op_val    = 2'(val);
        repeat (hold) tick();
        key_press = 1'b0;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        repeat (2) tick();
        modelKey(kind, val);
    endtask

    task automatic deliverDone(input int res);
        alu_result = DW'(res);
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        tick();
        modelDone(res);
    endtask

    task automatic doReset();
        key_press = 1'b0;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        alu_done = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        modelReset();
    endtask

    function automatic int randBcd();
        int v = 0;
        for (int d = 0; d < NDIG; d++) v = v * 16 + int'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int base;
        int wp;

        rst = 1'b1; key_press = 1'b0;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        num_val = 4'd0; op_val = 2'd0;
        alu_done = 1'b0; alu_result = '0;

        vecs[0]  = '{K_NUM,  1, 'h1,    0,    0, 'h1,    0};
        vecs[1]  = '{K_NUM,  2, 'h12,   0,    0, 'h12,   0};
        vecs[2]  = '{K_EQ,   0, 'h12,   0,    0, 'h12,   0};
        vecs[3]  = '{K_OP,   0, 'h12,   0,    0, 'h12,   0};
        vecs[4]  = '{K_OP,   3, 'h12,   0,    0, 'h12,   0};
        vecs[5]  = '{K_NONE, 0, 'h12,   0,    0, 'h12,   0};
        vecs[6]  = '{K_NUM,  3, 'h123,  0,    0, 'h123,  0};
        vecs[7]  = '{K_NUM,  4, 'h1234, 0,    0, 'h1234, 0};
        vecs[8]  = '{K_NUM,  5, 'h1234, 0,    0, 'h1234, 0};
        vecs[9]  = '{K_OP,   2, 'h1234, 0,    2, 0,      1};
        vecs[10] = '{K_NUM,  7, 'h1234, 'h7,  2, 'h7,    1};
        vecs[11] = '{K_OP,   1, 'h1234, 'h7,  1, 'h7,    1};
        vecs[12] = '{K_OP,   3, 'h1234, 'h7,  1, 'h7,    1};
        vecs[13] = '{K_NUM,  0, 'h1234, 'h70, 1, 'h70,   1};
        vecs[14] = '{K_EQ,   0, 'h1234, 'h70, 1, 0,      2};
        vecs[15] = '{K_EQ,   0, 'h1234, 'h70, 1, 0,      2};
        vecs[16] = '{K_NUM,  9, 'h1234, 'h70, 1, 0,      2};

        // Reset state.
        doReset();
        checkOutput("reset opnd_a",    opnd_a,    0);
        checkOutput("reset opnd_b",    opnd_b,    0);
        checkOutput("reset disp_val",  disp_val,  0);
        checkOutput("reset op_sel",    op_sel,    0);
        checkOutput("reset err",       err,       0);
        checkOutput("reset state",     state_o,   0);
        checkOutput("reset alu_start", alu_start, 0);

        // Table-driven key sequence.
        base = start_cnt;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].kind, vecs[i].val, 1 + i % 3);
            checkOutput($sformatf("vec%0d opnd_a", i),   opnd_a,   vecs[i].exp_a);
            checkOutput($sformatf("vec%0d opnd_b", i),   opnd_b,   vecs[i].exp_b);
            checkOutput($sformatf("vec%0d op_sel", i),   op_sel,   vecs[i].exp_op);
            checkOutput($sformatf("vec%0d disp_val", i), disp_val, vecs[i].exp_disp);
            checkOutput($sformatf("vec%0d state", i),    state_o,  vecs[i].exp_state);
        end
        checkOutput("vec starts", start_cnt - base, 1);
        deliverDone('h1304);
        checkOutput("vec result disp", disp_val, 'h1304);
        checkOutput("vec result state", state_o, 3);
        applyStimulus(K_EQ, 0, 1);
        checkOutput("show eq ignored", state_o, 3);
        applyStimulus(K_NUM, 6, 2);
        checkOutput("show digit opnd_a", opnd_a, 'h6);
        checkOutput("show digit state", state_o, 0);
        checkModel("after table");

        // 1 2 + 3 = then result 0x15.
        doReset();
        base = start_cnt;
        applyStimulus(K_NUM, 1, 1);
        applyStimulus(K_NUM, 2, 1);
        applyStimulus(K_OP, 1, 1);
        applyStimulus(K_NUM, 3, 1);
        applyStimulus(K_EQ, 0, 1);
        checkOutput("add starts",  start_cnt - base, 1);
        checkOutput("add opnd_a",  opnd_a,  'h12);
        checkOutput("add opnd_b",  opnd_b,  'h3);
        checkOutput("add op_sel",  op_sel,  1);
        checkOutput("add state",   state_o, 2);
        deliverDone('h15);
        checkOutput("add disp",    disp_val, 'h15);
        checkOutput("add state2",  state_o, 3);
        checkModel("add");

        // - 4 = from a shown result.
        applyStimulus(K_OP, 2, 1);
        applyStimulus(K_NUM, 4, 1);
        applyStimulus(K_EQ, 0, 1);
`ifdef CALC_CHAIN_EN
        checkOutput("chain opnd_a", opnd_a,  'h15);
        checkOutput("chain opnd_b", opnd_b,  'h4);
        checkOutput("chain op_sel", op_sel,  2);
        checkOutput("chain state",  state_o, 2);
`else
        checkOutput("nochain opnd_a", opnd_a,  'h4);
        checkOutput("nochain opnd_b", opnd_b,  0);
        checkOutput("nochain op_sel", op_sel,  1);
        checkOutput("nochain state",  state_o, 0);
`endif
        checkModel("chain");

        // Key held for 1000 cycles shifts exactly once.
        doReset();
        applyStimulus(K_NUM, 5, 1000);
        checkOutput("held opnd_a", opnd_a, 'h5);
        checkModel("held");

        // Fifth digit is dropped.
        doReset();
        for (int d = 1; d <= 5; d++) applyStimulus(K_NUM, d, 1);
        checkOutput("5dig opnd_a", opnd_a, 'h1234);
        checkModel("5dig");

        // Key held through reset produces no event.
        key_press = 1'b1; is_num = 1'b1; num_val = 4'd5;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("rsthold opnd_a", opnd_a, 0);
        key_press = 1'b0; is_num = 1'b0;
        repeat (2) tick();
        modelReset();
        checkModel("rsthold");
        applyStimulus(K_NUM, 6, 1);
        checkOutput("rsthold next", opnd_a, 'h6);

        // Timeout boundary: still waiting one cycle before the limit.
        doReset();
        applyStimulus(K_NUM, 1, 1);
        applyStimulus(K_OP, 1, 1);
        applyStimulus(K_NUM, 2, 1);
        applyStimulus(K_EQ, 0, 1);
        repeat (TMO - 2) tick();
        checkOutput("tmo-1 state", state_o, 2);
        checkOutput("tmo-1 err",   err,     0);
        tick();
        checkOutput("tmo err",     err,      1);
        checkOutput("tmo state",   state_o,  0);
        checkOutput("tmo disp",    disp_val, 0);
        modelTimeout();
        checkModel("tmo");
        applyStimulus(K_OP, 2, 1);
        checkOutput("tmo op keeps err", err, 1);
        applyStimulus(K_NUM, 8, 1);
        checkOutput("tmo digit clears err", err, 0);
        checkModel("tmo clear");

        // Completion on the last allowed cycle is accepted.
        doReset();
        applyStimulus(K_NUM, 1, 1);
        applyStimulus(K_OP, 2, 1);
        applyStimulus(K_NUM, 2, 1);
        applyStimulus(K_EQ, 0, 1);
        repeat (TMO - 2) tick();
        alu_result = DW'('h99);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        modelDone('h99);
        checkOutput("lastcyc state", state_o,  3);
        checkOutput("lastcyc disp",  disp_val, 'h99);
        checkOutput("lastcyc err",   err,      0);

        // Reset during WAIT_ALU, then a late completion.
        doReset();
        applyStimulus(K_NUM, 1, 1);
        applyStimulus(K_OP, 1, 1);
        applyStimulus(K_NUM, 2, 1);
        applyStimulus(K_EQ, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        modelReset();
        deliverDone('h77);
        checkOutput("rstwait opnd_a", opnd_a,    0);
        checkOutput("rstwait disp",   disp_val,  0);
        checkOutput("rstwait alu_start", alu_start, 0);
        checkModel("rstwait");

        // Completion outside WAIT_ALU is ignored.
        doReset();
        applyStimulus(K_NUM, 3, 1);
        deliverDone('h55);
        checkModel("stray done");

        // Random keys and ALU responses against the model.
        doReset();
        wp = 0;
        for (int i = 0; i < 300; i++) begin
            int r;
            int k;
            r = int'($urandom_range(0, 99));
            if (m_state == 2) begin
                if (wp >= 4 || r < 50) begin
                    deliverDone(randBcd());
                end else if (r < 58) begin
                    repeat (TMO + 2) tick();
                    modelTimeout();
                end else begin
                    applyStimulus(int'($urandom_range(0, 3)),
                                  int'($urandom_range(0, 9)),
                                  int'($urandom_range(1, 4)));
                    wp++;
                end
            end else begin
                wp = 0;
                if (r < 5) begin
                    deliverDone(randBcd());
                end else begin
                    k = int'($urandom_range(0, 9));
                    if (k < 5)
                        applyStimulus(K_NUM, int'($urandom_range(0, 9)),
                                      int'($urandom_range(1, 4)));
                    else if (k < 7)
                        applyStimulus(K_OP, int'($urandom_range(0, 3)),
                                      int'($urandom_range(1, 4)));
                    else if (k < 9)
                        applyStimulus(K_EQ, 0, int'($urandom_range(1, 4)));
                    else
                        applyStimulus(K_NONE, 0, int'($urandom_range(1, 4)));
                end
            end
            checkModel($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
